// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-client SDRAM port arbiter.
package sdram_arb_pkg;
   localparam int ADDR_W_DEF = 25;
   localparam int DATA_W_DEF = 16;

   localparam logic CLIENT0 = 1'b0;
   localparam logic CLIENT1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } arb_state_e;
endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes to the client != last.
module sdram_rr_pick
   import sdram_arb_pkg::*;
(
   input  logic [1:0] ireq,
   input  logic       ilast,
   output logic       ovalid,
   output logic       opick
);
   always_comb begin
      ovalid = |ireq;
      case (ireq)
         2'b01:   opick = CLIENT0;
         2'b10:   opick = CLIENT1;
         default: opick = ~ilast;
      endcase
   end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one sdram_controller between two single-word clients,
// with a sticky wait-for-ack watchdog. All outputs come straight from flops.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              iclk,
   input  logic              ireset,
   input  logic              ic0_req,
   input  logic              ic0_we,
   input  logic [ADDR_W-1:0] ic0_addr,
   input  logic [DATA_W-1:0] ic0_wdata,
   output logic              oc0_ack,
   output logic [DATA_W-1:0] oc0_rdata,
   input  logic              ic1_req,
   input  logic              ic1_we,
   input  logic [ADDR_W-1:0] ic1_addr,
   input  logic [DATA_W-1:0] ic1_wdata,
   output logic              oc1_ack,
   output logic [DATA_W-1:0] oc1_rdata,
   output logic              owrite_req,
   output logic [ADDR_W-1:0] owrite_address,
   output logic [DATA_W-1:0] owrite_data,
   input  logic              iwrite_ack,
   output logic              oread_req,
   output logic [ADDR_W-1:0] oread_address,
   input  logic [DATA_W-1:0] iread_data,
   input  logic              iread_ack,
   output logic              obusy,
   output logic              ogrant,
   output logic              otimeout
);
   localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   CNT_TRIP = CW'(TIMEOUT_CYCLES - 1);

   arb_state_e        state_q, state_d;
   logic              last_q, last_d;
   logic              grant_q, grant_d;
   logic              wreq_q, wreq_d;
   logic              rreq_q, rreq_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              c0_ack_q, c0_ack_d;
   logic              c1_ack_q, c1_ack_d;
   logic [DATA_W-1:0] c0_rdata_q, c0_rdata_d;
   logic [DATA_W-1:0] c1_rdata_q, c1_rdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
   logic              busy_q, busy_d;

   logic              pick_valid;
   logic              pick;
   logic              sel_we;
   logic              ack_match;

   sdram_rr_pick u_pick (
      .ireq   ({ic1_req, ic0_req}),
      .ilast  (last_q),
      .ovalid (pick_valid),
      .opick  (pick)
   );

   assign sel_we    = (pick == CLIENT1) ? ic1_we : ic0_we;
   // Only the ack matching the outstanding request type counts.
   assign ack_match = (wreq_q && iwrite_ack) || (rreq_q && iread_ack);

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_d    = grant_q;
      wreq_d     = wreq_q;
      rreq_d     = rreq_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      c0_ack_d   = 1'b0;
      c1_ack_d   = 1'b0;
      c0_rdata_d = c0_rdata_q;
      c1_rdata_d = c1_rdata_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick;
               addr_d  = (pick == CLIENT1) ? ic1_addr  : ic0_addr;
               wdata_d = (pick == CLIENT1) ? ic1_wdata : ic0_wdata;
               wreq_d  = sel_we;
               rreq_d  = ~sel_we;
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != CNT_MAX)
               cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_TRIP)
               timeout_d = 1'b1;
            if (ack_match) begin
               wreq_d = 1'b0;
               rreq_d = 1'b0;
               last_d = grant_q;
               if (rreq_q) begin
                  if (grant_q == CLIENT1) c1_rdata_d = iread_data;
                  else                    c0_rdata_d = iread_data;
               end
               // Ack flops load here so the pulse lines up with the DONE cycle.
               if (grant_q == CLIENT1) c1_ack_d = 1'b1;
               else                    c0_ack_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         state_q    <= IDLE;
         last_q     <= CLIENT1;
         grant_q    <= 1'b0;
         wreq_q     <= 1'b0;
         rreq_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         c0_ack_q   <= 1'b0;
         c1_ack_q   <= 1'b0;
         c0_rdata_q <= '0;
         c1_rdata_q <= '0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         wreq_q     <= wreq_d;
         rreq_q     <= rreq_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         c0_ack_q   <= c0_ack_d;
         c1_ack_q   <= c1_ack_d;
         c0_rdata_q <= c0_rdata_d;
         c1_rdata_q <= c1_rdata_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
      end
   end

   assign oc0_ack        = c0_ack_q;
   assign oc0_rdata      = c0_rdata_q;
   assign oc1_ack        = c1_ack_q;
   assign oc1_rdata      = c1_rdata_q;
   assign owrite_req     = wreq_q;
   assign owrite_address = addr_q;
   assign owrite_data    = wdata_q;
   assign oread_req      = rreq_q;
   assign oread_address  = addr_q;
   assign obusy          = busy_q;
   assign ogrant         = grant_q;
   assign otimeout       = timeout_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a delayed-ack controller model.
module tb_sdram_port_arbiter;
   localparam int AW = 25;
   localparam int DW = 16;

   logic          iclk = 1'b0;
   logic          ireset;
   logic          ic0_req, ic0_we, ic1_req, ic1_we;
   logic [AW-1:0] ic0_addr, ic1_addr;
   logic [DW-1:0] ic0_wdata, ic1_wdata;
   logic          oc0_ack, oc1_ack;
   logic [DW-1:0] oc0_rdata, oc1_rdata;
   logic          owrite_req, oread_req, iwrite_ack, iread_ack;
   logic [AW-1:0] owrite_address, oread_address;
   logic [DW-1:0] owrite_data, iread_data;
   logic          obusy, ogrant, otimeout;

   logic          m_wack, m_rack, t_wack, t_rack;
   logic [DW-1:0] m_data;
   int            ack_delay = 3;
   bit            model_en = 1'b1;
   logic [DW-1:0] model_rdata = '0;
   int            n_vec = 0;
   int            n_miscmp = 0;

   assign iwrite_ack = m_wack | t_wack;
   assign iread_ack  = m_rack | t_rack;
   assign iread_data = m_data;

   always #5 iclk = ~iclk;

   sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
      .iclk(iclk), .ireset(ireset),
      .ic0_req(ic0_req), .ic0_we(ic0_we), .ic0_addr(ic0_addr), .ic0_wdata(ic0_wdata),
      .oc0_ack(oc0_ack), .oc0_rdata(oc0_rdata),
      .ic1_req(ic1_req), .ic1_we(ic1_we), .ic1_addr(ic1_addr), .ic1_wdata(ic1_wdata),
      .oc1_ack(oc1_ack), .oc1_rdata(oc1_rdata),
      .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
      .iwrite_ack(iwrite_ack),
      .oread_req(oread_req), .oread_address(oread_address), .iread_data(iread_data),
      .iread_ack(iread_ack),
      .obusy(obusy), .ogrant(ogrant), .otimeout(otimeout)
   );

   // Controller model: acks the pending request on its ack_delay-th cycle.
   initial begin
      int wcnt;
      wcnt = 0;
      m_wack = 1'b0; m_rack = 1'b0; m_data = '0;
      forever begin
         @(negedge iclk);
         m_wack = 1'b0; m_rack = 1'b0;
         if (model_en && !ireset && (owrite_req || oread_req)) begin
            wcnt++;
            if (wcnt >= ack_delay) begin
               wcnt = 0;
               if (owrite_req) m_wack = 1'b1;
               else begin m_rack = 1'b1; m_data = model_rdata; end
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge iclk);
      #1;
   endtask

   task automatic do_reset();
      ireset = 1'b1;
      tick(); tick();
      ireset = 1'b0;
      tick();
   endtask

   // One client transaction; reports tick numbers of first downstream req,
   // controller ack, client ack and otimeout rise (tick 1 = first cycle after req sampled).
   task automatic do_txn(input int c, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int delay,
                         output int req_t, output int cack_t, output int dack_t,
                         output int to_t, output int nacks, output int errs,
                         output logic [DW-1:0] rd);
      logic own_ack, oth_ack;
      ack_delay = delay;
      req_t = -1; cack_t = -1; dack_t = -1; to_t = -1; nacks = 0; errs = 0; rd = '0;
      if (c == 0) begin ic0_we = we; ic0_addr = a; ic0_wdata = d; ic0_req = 1'b1; end
      else        begin ic1_we = we; ic1_addr = a; ic1_wdata = d; ic1_req = 1'b1; end
      for (int t = 1; t <= 60; t++) begin
         tick();
         own_ack = (c == 0) ? oc0_ack : oc1_ack;
         oth_ack = (c == 0) ? oc1_ack : oc0_ack;
         if (owrite_req && oread_req) errs++;
         if (owrite_req || oread_req) begin
            if (req_t < 0) req_t = t;
            if (owrite_req !== we) errs++;
            if (we && (owrite_address !== a || owrite_data !== d)) errs++;
            if (!we && oread_address !== a) errs++;
         end
         if (cack_t < 0 && (we ? iwrite_ack : iread_ack)) cack_t = t;
         if (to_t < 0 && otimeout) to_t = t;
         if (oth_ack) errs++;
         if (own_ack) begin
            nacks++;
            if (owrite_req || oread_req) errs++;
            if (dack_t < 0) begin
               dack_t = t;
               rd = (c == 0) ? oc0_rdata : oc1_rdata;
            end
            if (c == 0) ic0_req = 1'b0; else ic1_req = 1'b0;
         end
         if (dack_t > 0 && t >= dack_t + 3) break;
      end
      if (c == 0) ic0_req = 1'b0; else ic1_req = 1'b0;
      $display("txn c%0d we=%0d addr=0x%07h req@%0d cack@%0d dack@%0d acks=%0d rdata=0x%04h",
               c, we, a, req_t, cack_t, dack_t, nacks, rd);
   endtask

   initial begin
      int req_t, cack_t, dack_t, to_t, nacks, errs, ng, stray;
      logic [DW-1:0] rd;
      logic prev_busy, after_done;
      logic [1:0] grants [4];

      ireset = 1'b1;
      ic0_req = 0; ic0_we = 0; ic0_addr = '0; ic0_wdata = '0;
      ic1_req = 0; ic1_we = 0; ic1_addr = '0; ic1_wdata = '0;
      t_wack = 0; t_rack = 0;
      tick(); tick();
      check_val("rst_busy",  obusy, 0);
      check_val("rst_grant", ogrant, 0);
      check_val("rst_to",    otimeout, 0);
      check_val("rst_reqs",  {owrite_req, oread_req}, 0);
      check_val("rst_acks",  {oc0_ack, oc1_ack}, 0);
      check_val("rst_waddr", owrite_address, 0);
      check_val("rst_rdata", {oc0_rdata, oc1_rdata}, 0);
      ireset = 1'b0;
      tick();

      // Client0 write, ack after 5 cycles
      do_txn(0, 1'b1, 25'h0ABCDEF, 16'h1234, 5, req_t, cack_t, dack_t, to_t, nacks, errs, rd);
      check_val("t1_req_t",  req_t, 1);
      check_val("t1_cack_t", cack_t, 5);
      check_val("t1_dack_t", dack_t, 6);
      check_val("t1_nacks",  nacks, 1);
      check_val("t1_errs",   errs, 0);
      check_val("t1_grant",  ogrant, 0);

      // Client1 read returning 0xBEEF
      model_rdata = 16'hBEEF;
      do_txn(1, 1'b0, 25'h1000000, 16'h0000, 3, req_t, cack_t, dack_t, to_t, nacks, errs, rd);
      check_val("t2_dack_t",  dack_t, 4);
      check_val("t2_rd_ack",  rd, 16'hBEEF);
      check_val("t2_errs",    errs, 0);
      check_val("t2_nacks",   nacks, 1);
      check_val("t2_held",    oc1_rdata, 16'hBEEF);
      check_val("t2_c0_rd",   oc0_rdata, 16'h0000);
      check_val("t2_grant",   ogrant, 1);

      // Both clients requesting continuously from reset
      do_reset();
      ack_delay = 2;
      ic0_we = 1; ic0_addr = 25'h0000111; ic0_wdata = 16'hA0A0;
      ic1_we = 0; ic1_addr = 25'h0000222;
      ic0_req = 1; ic1_req = 1;
      ng = 0; stray = 0; prev_busy = 0; after_done = 0;
      for (int t = 0; t < 200 && ng < 4; t++) begin
         tick();
         if (after_done) begin
            if (obusy || owrite_req || oread_req) stray++;
            after_done = 0;
         end
         if (obusy && !prev_busy) begin
            grants[ng] = {1'b0, ogrant};
            $display("grant %0d -> client%0d", ng, ogrant);
            ng++;
         end
         if (oc0_ack || oc1_ack) after_done = 1;
         prev_busy = obusy;
      end
      ic0_req = 0; ic1_req = 0;
      check_val("t3_ngrants", ng, 4);
      check_val("t3_g0", grants[0], 0);
      check_val("t3_g1", grants[1], 1);
      check_val("t3_g2", grants[2], 0);
      check_val("t3_g3", grants[3], 1);
      check_val("t3_idle_gap", stray, 0);
      for (int i = 0; i < 10; i++) tick();
      check_val("t3_drained", obusy, 0);

      // Unmatched acks: read ack during write WAIT, acks while idle
      model_en = 0;
      ic0_we = 1; ic0_addr = 25'h0000333; ic0_wdata = 16'h3333; ic0_req = 1;
      tick();
      check_val("t6_wreq", owrite_req, 1);
      t_rack = 1;
      tick();
      t_rack = 0;
      check_val("t6_busy", obusy, 1);
      check_val("t6_noack", {oc0_ack, oc1_ack}, 0);
      tick();
      check_val("t6_still", {obusy, owrite_req, oread_req}, 3'b110);
      t_wack = 1; t_rack = 1;
      tick();
      t_wack = 0; t_rack = 0;
      check_val("t6_both_ack", {oc0_ack, oc1_ack}, 2'b10);
      ic0_req = 0;
      tick();
      check_val("t6_idle", obusy, 0);
      t_wack = 1; t_rack = 1;
      tick();
      t_wack = 0; t_rack = 0;
      tick();
      check_val("t6_idle_ack", {obusy, oc0_ack, oc1_ack, owrite_req, oread_req}, 0);
      model_en = 1;
      $display("txn unmatched-ack sequence done");

      // Watchdog: ack withheld 20 cycles
      check_val("t4_to_pre", otimeout, 0);
      model_rdata = 16'h7E57;
      do_txn(0, 1'b0, 25'h0000123, 16'h0000, 20, req_t, cack_t, dack_t, to_t, nacks, errs, rd);
      check_val("t4_to_t",   to_t, 17);
      check_val("t4_cack_t", cack_t, 20);
      check_val("t4_dack_t", dack_t, 21);
      check_val("t4_rd",     rd, 16'h7E57);
      check_val("t4_sticky", otimeout, 1);

      // Reset during WAIT, then tie goes to client0
      ack_delay = 50;
      ic1_we = 1; ic1_addr = 25'h1555555; ic1_wdata = 16'h9999; ic1_req = 1;
      tick(); tick(); tick();
      check_val("t5_wait", {obusy, ogrant, owrite_req}, 3'b111);
      ireset = 1'b1;
      #1;
      check_val("t5_async_flags", {obusy, ogrant, otimeout, owrite_req, oread_req, oc0_ack, oc1_ack}, 0);
      check_val("t5_async_addr", owrite_address, 0);
      check_val("t5_async_data", owrite_data, 0);
      check_val("t5_async_rd", oc0_rdata, 0);
      ic0_we = 0; ic0_addr = 25'h0F0F0F0; ic0_req = 1;
      tick();
      ireset = 1'b0;
      tick();
      check_val("t5_grant", ogrant, 0);
      check_val("t5_rreq", {owrite_req, oread_req}, 2'b01);
      check_val("t5_raddr", oread_address, 25'h0F0F0F0);
      ack_delay = 2;
      ic0_req = 0; ic1_req = 0;
      for (int i = 0; i < 10; i++) tick();
      check_val("t5_drained", obusy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end
endmodule
